char_mem_loader: RTL and testbench

- Sole write-port controller for the 1500-cell character display RAM (50 cols x 30 rows, 6-bit glyph codes) read by the VGA pixel pipeline.
- After reset and on request, sequences a full-screen init: blank interior with a filled border.
- Otherwise accepts asynchronous host writes (strobe + 11-bit address + 6-bit code from the GPIO bus), synchronizes and validates them, queues them, and applies them to the RAM in order.

---
 rtl/char_mem_loader.sv | 193 +++++++++++++++++++
 tb/tb_char_mem_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_mem_loader.sv
// Sole write-port controller for the character display RAM: a border/blank
// init fill after reset or on request, then in-order application of host writes.
module char_mem_loader #(
    parameter int unsigned COLS        = 50,
    parameter int unsigned ROWS        = 30,
    parameter int unsigned CELLS       = COLS * ROWS,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned CHAR_W      = 6,
    parameter int unsigned NUM_GLYPHS  = 59,
    parameter int unsigned BLANK_CODE  = 57,
    parameter int unsigned BORDER_CODE = 58,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              host_strobe,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [CHAR_W-1:0] host_char,
    input  logic              clear_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CHAR_W-1:0] mem_data,
    output logic              busy,
    output logic              fifo_full,
    output logic [7:0]        reject_count,
    output logic [7:0]        drop_count
);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CHAR_W-1:0] code;
    } wr_req_t;

    typedef enum logic {S_FILL, S_RUN} state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [2:0]        strobe_q;
    logic [ADDR_W-1:0] addr_s1_q, addr_s2_q;
    logic [CHAR_W-1:0] char_s1_q, char_s2_q;

    wr_req_t           fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q;
    logic [7:0]        reject_q, drop_q;

    state_t            state_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic              mem_we_q, busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [CHAR_W-1:0] mem_data_q;

    logic edge_c, valid_c, push_req_c, reject_c, clear_c, pop_c, push_ok_c, drop_c, border_c;

    // Two-flop synchronizers; strobe gets a third stage for edge detection.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            strobe_q  <= '0;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            char_s1_q <= '0;
            char_s2_q <= '0;
        end else begin
            strobe_q  <= {strobe_q[1:0], host_strobe};
            addr_s1_q <= host_addr;
            addr_s2_q <= addr_s1_q;
            char_s1_q <= host_char;
            char_s2_q <= char_s1_q;
        end
    end

    always_comb begin
        edge_c     = strobe_q[1] & ~strobe_q[2];
        valid_c    = (addr_s2_q < ADDR_W'(CELLS)) && (char_s2_q < CHAR_W'(NUM_GLYPHS));
        push_req_c = edge_c & valid_c;
        reject_c   = edge_c & ~valid_c;
        clear_c    = (state_q == S_RUN) && clear_req;
        pop_c      = (state_q == S_RUN) && !clear_req && (count_q != '0);
        // A flush empties the queue, so the coincident push always has room.
        push_ok_c  = push_req_c && ((count_q != FULL_CNT) || pop_c || clear_c);
        drop_c     = push_req_c && !push_ok_c;
        border_c   = (row_q == '0) || (row_q == LAST_ROW) || (col_q == '0) || (col_q == LAST_COL);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_c) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (clear_c) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = CNT_W'(push_ok_c);
        end else begin
            if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok_c) fifo_mem_q[wr_ptr_q] <= '{addr: addr_s2_q, code: char_s2_q};
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            reject_q <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            if (reject_c && reject_q != 8'hFF) reject_q <= reject_q + 8'd1;
            if (drop_c && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    // Fill sequencer and RAM write port.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_FILL;
            row_q       <= '0;
            col_q       <= '0;
            fill_addr_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            busy_q      <= 1'b1;
        end else begin
            mem_we_q <= 1'b0;
            busy_q   <= (state_q == S_FILL);
            case (state_q)
                S_FILL: begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= fill_addr_q;
                    mem_data_q <= border_c ? CHAR_W'(BORDER_CODE) : CHAR_W'(BLANK_CODE);
                    if (fill_addr_q == LAST_CELL) begin
                        state_q     <= S_RUN;
                        fill_addr_q <= '0;
                        row_q       <= '0;
                        col_q       <= '0;
                    end else begin
                        fill_addr_q <= fill_addr_q + ADDR_W'(1);
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (clear_req) begin
                        state_q <= S_FILL;
                        busy_q  <= 1'b1;
                    end else if (pop_c) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= fifo_mem_q[rd_ptr_q].addr;
                        mem_data_q <= fifo_mem_q[rd_ptr_q].code;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign busy         = busy_q;
    assign fifo_full    = full_q;
    assign reject_count = reject_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_char_mem_loader.sv
// Self-checking bench for char_mem_loader: fill pattern, host write path,
// validation, queue overflow, clear/flush and reset abort.
module tb_char_mem_loader;
    localparam int COLS = 50;
    localparam int ROWS = 30;
    localparam int CELLS = 1500;
    localparam int NUM_GLYPHS = 59;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_strobe = 1'b0;
    logic [10:0] host_addr = '0;
    logic [5:0]  host_char = '0;
    logic        clear_req = 1'b0;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [5:0]  mem_data;
    logic        busy, fifo_full;
    logic [7:0]  reject_count, drop_count;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t  obs_q[$];
    int   cyc = 0;
    int   busy_fall_cyc = -1;
    logic busy_prev = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    int   exp_rej = 0;
    int   exp_drop = 0;

    char_mem_loader dut (
        .CLK(clk), .RESETN(rst_n), .host_strobe(host_strobe), .host_addr(host_addr),
        .host_char(host_char), .clear_req(clear_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .fifo_full(fifo_full),
        .reject_count(reject_count), .drop_count(drop_count)
    );

    always #25 clk = ~clk;
    always @(posedge clk) cyc++;

    // Record every RAM write with the cycle it appeared in.
    always @(negedge clk) begin
        if (mem_we === 1'b1) obs_q.push_back('{int'(mem_addr), int'(mem_data), cyc});
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    function automatic int exp_code(input int a);
        int r = a / COLS;
        int c = a % COLS;
        return (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) ? 58 : 57;
    endfunction

    // Number of cells of a full-screen fill starting at obs_q[base] that are wrong.
    function automatic int fill_bad(input int base, output int first);
        int nbad = 0;
        first = -1;
        for (int i = 0; i < CELLS; i++) begin
            if (base + i >= obs_q.size() || obs_q[base+i].addr != i ||
                obs_q[base+i].data != exp_code(i) || obs_q[base+i].cyc != obs_q[base].cyc + i) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        return nbad;
    endfunction

    task automatic host_write(input logic [10:0] a, input logic [5:0] c);
        @(negedge clk);
        host_addr = a;
        host_char = c;
        repeat (3) @(negedge clk);
        host_strobe = 1'b1;
        repeat (3) @(negedge clk);
        host_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    task automatic wait_busy_low(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 11'd0) begin n_err++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        n_checks++; if (mem_data !== 6'd0) begin n_err++; $display("FAIL reset_mem_data: got %0d want 0", mem_data); end
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_checks++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_fifo_full: got %b want 0", fifo_full); end
        n_checks++; if (reject_count !== 8'd0) begin n_err++; $display("FAIL reset_reject: got %0d want 0", reject_count); end
        n_checks++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        obs_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_init_fill();
        bit ok;
        int first, nbad;
        int pts [10]  = '{0, 49, 50, 99, 1449, 1450, 1499, 51, 725, 1448};
        int want [10] = '{58, 58, 58, 58, 58, 58, 58, 57, 57, 57};
        wait_busy_low(ok);
        n_checks++; if (!ok) begin n_err++; $display("FAIL init_busy_timeout: busy got %b want 0", busy); end
        repeat (5) @(negedge clk);
        n_checks++; if (obs_q.size() != CELLS) begin n_err++; $display("FAIL init_write_count: got %0d want %0d", obs_q.size(), CELLS); end
        nbad = fill_bad(0, first);
        n_checks++; if (nbad != 0) begin n_err++; $display("FAIL init_fill_cells: got %0d bad cells (first %0d) want 0", nbad, first); end
        for (int j = 0; j < 10; j++) begin
            if (obs_q.size() > pts[j]) begin
                n_checks++;
                if (obs_q[pts[j]].data != want[j]) begin
                    n_err++; $display("FAIL init_spot_%0d: got data %0d want %0d", pts[j], obs_q[pts[j]].data, want[j]);
                end
            end
        end
        if (obs_q.size() >= CELLS) begin
            n_checks++;
            if (busy_fall_cyc != obs_q[CELLS-1].cyc + 1) begin
                n_err++; $display("FAIL init_busy_fall: got cycle %0d want %0d", busy_fall_cyc, obs_q[CELLS-1].cyc + 1);
            end
        end
    endtask

    task automatic test_latency();
        int other = 0;
        @(negedge clk);
        host_addr = 11'd51;
        host_char = 6'd0;
        repeat (3) @(negedge clk);
        host_strobe = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) host_strobe = 1'b0;
            if (k == 4) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== 11'd51 || mem_data !== 6'd0) begin
                    n_err++; $display("FAIL latency_write: got we=%b addr=%0d data=%0d want we=1 addr=51 data=0", mem_we, mem_addr, mem_data);
                end
            end else if (mem_we !== 1'b0) begin
                other++;
            end
        end
        n_checks++; if (other != 0) begin n_err++; $display("FAIL latency_extra_writes: got %0d want 0", other); end
    endtask

    task automatic test_reject();
        obs_q.delete();
        host_write(11'd1500, 6'd5); exp_rej++;
        host_write(11'd10, 6'd59);  exp_rej++;
        repeat (5) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) begin n_err++; $display("FAIL reject_writes: got %0d want 0", obs_q.size()); end
        n_checks++; if (reject_count !== 8'(exp_rej)) begin n_err++; $display("FAIL reject_count: got %0d want %0d", reject_count, exp_rej); end
        n_checks++; if (drop_count !== 8'(exp_drop)) begin n_err++; $display("FAIL reject_drop: got %0d want %0d", drop_count, exp_drop); end
    endtask

    task automatic test_fill_overflow();
        bit ok;
        int first, nbad, nq;
        obs_q.delete();
        pulse_clear();
        for (int j = 0; j < 6; j++) begin
            host_write(11'(100 + j), 6'(1 + j));
            if (j == 2) begin
                n_checks++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL ovf_full_after3: got %b want 0", fifo_full); end
            end
            if (j == 3) begin
                n_checks++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full_after4: got %b want 1", fifo_full); end
            end
        end
        nq = (6 < DEPTH) ? 6 : DEPTH;
        exp_drop += 6 - nq;
        n_checks++; if (drop_count !== 8'(exp_drop)) begin n_err++; $display("FAIL ovf_drop_count: got %0d want %0d", drop_count, exp_drop); end
        wait_busy_low(ok);
        n_checks++; if (!ok) begin n_err++; $display("FAIL ovf_busy_timeout: busy got %b want 0", busy); end
        repeat (10) @(negedge clk);
        n_checks++; if (obs_q.size() != CELLS + nq) begin n_err++; $display("FAIL ovf_write_count: got %0d want %0d", obs_q.size(), CELLS + nq); end
        nbad = fill_bad(0, first);
        n_checks++; if (nbad != 0) begin n_err++; $display("FAIL ovf_fill_cells: got %0d bad cells (first %0d) want 0", nbad, first); end
        for (int j = 0; j < nq; j++) begin
            if (obs_q.size() > CELLS + j) begin
                n_checks++;
                if (obs_q[CELLS+j].addr != 100 + j || obs_q[CELLS+j].data != 1 + j || obs_q[CELLS+j].cyc != obs_q[CELLS].cyc + j) begin
                    n_err++; $display("FAIL ovf_drain_%0d: got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                        j, obs_q[CELLS+j].addr, obs_q[CELLS+j].data, obs_q[CELLS+j].cyc, 100 + j, 1 + j, obs_q[CELLS].cyc + j);
                end
            end
        end
        n_checks++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL ovf_full_after_drain: got %b want 0", fifo_full); end
    endtask

    task automatic test_clear_with_push();
        bit ok;
        int n = 0;
        int first, nbad;
        obs_q.delete();
        pulse_clear();
        for (int j = 0; j < 4; j++) host_write(11'(200 + j), 6'(10 + j));
        host_addr = 11'd60;
        host_char = 6'd3;
        while (!(mem_we === 1'b1 && mem_addr === 11'd1499) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 3000) begin n_err++; $display("FAIL clr_last_fill_timeout: got no write to 1499 want one"); return; end
        // Strobe rises now so its edge is detected in the same cycle clear_req is high.
        host_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        host_strobe = 1'b0;
        wait_busy_low(ok);
        n_checks++; if (!ok) begin n_err++; $display("FAIL clr_busy_timeout: busy got %b want 0", busy); end
        repeat (10) @(negedge clk);
        n_checks++; if (obs_q.size() != 2 * CELLS + 3) begin n_err++; $display("FAIL clr_write_count: got %0d want %0d", obs_q.size(), 2 * CELLS + 3); end
        if (obs_q.size() == 2 * CELLS + 3) begin
            n_checks++;
            if (obs_q[CELLS].addr != 200 || obs_q[CELLS].data != 10 || obs_q[CELLS+1].addr != 201 || obs_q[CELLS+1].data != 11) begin
                n_err++; $display("FAIL clr_older_pair: got %0d/%0d %0d/%0d want 200/10 201/11",
                    obs_q[CELLS].addr, obs_q[CELLS].data, obs_q[CELLS+1].addr, obs_q[CELLS+1].data);
            end
            nbad = fill_bad(CELLS + 2, first);
            n_checks++; if (nbad != 0) begin n_err++; $display("FAIL clr_refill_cells: got %0d bad cells (first %0d) want 0", nbad, first); end
            n_checks++;
            if (obs_q[2*CELLS+2].addr != 60 || obs_q[2*CELLS+2].data != 3) begin
                n_err++; $display("FAIL clr_survivor: got addr=%0d data=%0d want addr=60 data=3", obs_q[2*CELLS+2].addr, obs_q[2*CELLS+2].data);
            end
            n_checks++;
            if (busy_fall_cyc != obs_q[2*CELLS+1].cyc + 1) begin
                n_err++; $display("FAIL clr_busy_fall: got cycle %0d want %0d", busy_fall_cyc, obs_q[2*CELLS+1].cyc + 1);
            end
        end
        n_checks++; if (drop_count !== 8'(exp_drop)) begin n_err++; $display("FAIL clr_drop_count: got %0d want %0d", drop_count, exp_drop); end
    endtask

    task automatic test_random_writes();
        wr_t exp_q[$];
        int nbad = 0;
        obs_q.delete();
        for (int j = 0; j < 24; j++) begin
            int a = int'($urandom_range(1599, 0));
            int c = int'($urandom_range(63, 0));
            host_write(11'(a), 6'(c));
            if (a < CELLS && c < NUM_GLYPHS) exp_q.push_back('{a, c, 0});
            else exp_rej++;
        end
        repeat (5) @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_write_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++)
            if (obs_q[j].addr != exp_q[j].addr || obs_q[j].data != exp_q[j].data) nbad++;
        n_checks++; if (nbad != 0) begin n_err++; $display("FAIL rand_write_order: got %0d mismatched writes want 0", nbad); end
        n_checks++; if (reject_count !== 8'(exp_rej)) begin n_err++; $display("FAIL rand_reject_count: got %0d want %0d", reject_count, exp_rej); end
        n_checks++; if (drop_count !== 8'(exp_drop)) begin n_err++; $display("FAIL rand_drop_count: got %0d want %0d", drop_count, exp_drop); end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        int n = 0;
        int first, nbad;
        pulse_clear();
        while (!(mem_we === 1'b1 && mem_addr === 11'd700) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 3000) begin n_err++; $display("FAIL rst_mid_timeout: got no write to 700 want one"); return; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mid_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 11'd0) begin n_err++; $display("FAIL rst_mid_mem_addr: got %0d want 0", mem_addr); end
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
        n_checks++; if (reject_count !== 8'd0 || drop_count !== 8'd0) begin
            n_err++; $display("FAIL rst_mid_counters: got reject=%0d drop=%0d want 0 0", reject_count, drop_count);
        end
        exp_rej = 0;
        exp_drop = 0;
        repeat (2) @(negedge clk);
        obs_q.delete();
        rst_n = 1'b1;
        wait_busy_low(ok);
        n_checks++; if (!ok) begin n_err++; $display("FAIL rst_mid_busy_timeout: busy got %b want 0", busy); end
        repeat (5) @(negedge clk);
        n_checks++; if (obs_q.size() != CELLS) begin n_err++; $display("FAIL rst_mid_write_count: got %0d want %0d", obs_q.size(), CELLS); end
        nbad = fill_bad(0, first);
        n_checks++; if (nbad != 0) begin n_err++; $display("FAIL rst_mid_fill_cells: got %0d bad cells (first %0d) want 0", nbad, first); end
    endtask

    initial begin
        test_reset();
        test_init_fill();
        test_latency();
        test_reject();
        test_fill_overflow();
        test_clear_with_push();
        test_random_writes();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got more than %0d cycles want completion", 60000);
        $fatal(1, "watchdog expired");
    end

endmodule
